// File: rtl/buf_addr_sched.sv
// Circular FIFO with registered occupancy; push and pop are both single-cycle, head is read combinationally.
// No backpressure of its own: the owner only pops when cnt > 0 and never pushes into a full FIFO.
module buf_addr_sched_fifo #(
  parameter int DEPTH = 16,
  parameter int DAT_W = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [DAT_W-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [DAT_W-1:0] head_dat,
  output logic [CNT_W-1:0] cnt
);
  localparam int AW = CNT_W - 1;

  logic [DAT_W-1:0] mem_q [DEPTH];
  logic [DAT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_rdy) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_vld, pop_rdy})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_vld && !pop_rdy && cnt_q == CNT_W'(DEPTH)));
      assert (!(pop_rdy && cnt_q == '0));
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;
endmodule

// Slot allocator/read scheduler: free list feeds write grants, desc FIFO orders reads, slots recycle on rd_done.
// Grant and read strobe 1 cycle after request; requests stall while no slot is free or one read is outstanding.
module buf_addr_sched #(
  parameter int SLOT_NUM   = 16,
  parameter int SLOT_W     = 4,
  parameter int SLOT_SHIFT = 7,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_pkt_req,
  output logic              out_pkt_ack,
  input  logic              in_pkt_eop,
  output logic [ADDR_W-1:0] addr2data_waddr,
  output logic              addr2data_waddr_wr,
  input  logic              in_ebm_ready,
  output logic [ADDR_W-1:0] addr2data_raddr,
  output logic              addr2data_raddr_wr,
  input  logic              in_rd_done,
  output logic [SLOT_W:0]   out_free_cnt,
  output logic [SLOT_W:0]   out_pkt_cnt,
  output logic              out_init_done
);
  typedef enum logic [1:0] {W_INIT = 2'd0, W_IDLE = 2'd1, W_BUSY = 2'd2} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_WAIT = 1'b1} rstate_e;

  wstate_e           wstate_q, wstate_d;
  rstate_e           rstate_q, rstate_d;
  logic [SLOT_W-1:0] init_idx_q, init_idx_d;
  logic              init_done_q, init_done_d;
  logic [SLOT_W-1:0] cur_wslot_q, cur_wslot_d;
  logic [SLOT_W-1:0] cur_rslot_q, cur_rslot_d;
  logic              ack_q, ack_d;
  logic              raddr_wr_q, raddr_wr_d;

  logic              free_push;
  logic [SLOT_W-1:0] free_push_dat;
  logic [SLOT_W-1:0] free_head;
  logic [SLOT_W:0]   free_cnt;
  logic              desc_push;
  logic [SLOT_W-1:0] desc_head;
  logic [SLOT_W:0]   pkt_cnt;

  logic wr_alloc;
  logic rd_issue;
  logic rd_release;

  // Pops look only at registered counts, so a slot released this cycle is usable next cycle.
  assign wr_alloc   = (wstate_q == W_IDLE) && in_pkt_req && (free_cnt != '0);
  assign rd_issue   = (rstate_q == R_IDLE) && init_done_q && in_ebm_ready && (pkt_cnt != '0);
  assign rd_release = (rstate_q == R_WAIT) && in_rd_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q    <= W_INIT;
      rstate_q    <= R_IDLE;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      cur_wslot_q <= '0;
      cur_rslot_q <= '0;
      ack_q       <= 1'b0;
      raddr_wr_q  <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      cur_wslot_q <= cur_wslot_d;
      cur_rslot_q <= cur_rslot_d;
      ack_q       <= ack_d;
      raddr_wr_q  <= raddr_wr_d;
    end
  end

  always_comb begin
    wstate_d   = wstate_q;
    init_idx_d = init_idx_q;
    case (wstate_q)
      W_INIT: begin
        init_idx_d = init_idx_q + SLOT_W'(1);
        if (init_idx_q == SLOT_W'(SLOT_NUM - 1)) wstate_d = W_IDLE;
      end
      W_IDLE:  if (wr_alloc) wstate_d = W_BUSY;
      W_BUSY:  if (in_pkt_eop) wstate_d = W_IDLE;
      default: wstate_d = W_INIT;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (rd_issue) rstate_d = R_WAIT;
      R_WAIT:  if (in_rd_done) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    free_push     = (wstate_q == W_INIT) || rd_release;
    free_push_dat = (wstate_q == W_INIT) ? init_idx_q : cur_rslot_q;
    desc_push     = (wstate_q == W_BUSY) && in_pkt_eop;
    cur_wslot_d   = wr_alloc ? free_head : cur_wslot_q;
    cur_rslot_d   = rd_issue ? desc_head : cur_rslot_q;
    ack_d         = wr_alloc;
    raddr_wr_d    = rd_issue;
    // Done flag trails the last init push by one cycle.
    init_done_d   = init_done_q || (wstate_q == W_IDLE);
  end

  buf_addr_sched_fifo #(
    .DEPTH (SLOT_NUM),
    .DAT_W (SLOT_W),
    .CNT_W (SLOT_W + 1)
  ) u_free_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (free_push),
    .push_dat (free_push_dat),
    .pop_rdy  (wr_alloc),
    .head_dat (free_head),
    .cnt      (free_cnt)
  );

  buf_addr_sched_fifo #(
    .DEPTH (SLOT_NUM),
    .DAT_W (SLOT_W),
    .CNT_W (SLOT_W + 1)
  ) u_desc_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (desc_push),
    .push_dat (cur_wslot_q),
    .pop_rdy  (rd_issue),
    .head_dat (desc_head),
    .cnt      (pkt_cnt)
  );

  assign out_pkt_ack        = ack_q;
  assign addr2data_waddr_wr = ack_q;
  assign addr2data_waddr    = {cur_wslot_q, {SLOT_SHIFT{1'b0}}};
  assign addr2data_raddr_wr = raddr_wr_q;
  assign addr2data_raddr    = {cur_rslot_q, {SLOT_SHIFT{1'b0}}};
  assign out_free_cnt       = free_cnt;
  assign out_pkt_cnt        = pkt_cnt;
  assign out_init_done      = init_done_q;
endmodule

// File: tb/tb_buf_addr_sched.sv
// Scoreboard bench for buf_addr_sched: queue model of free list and descriptor order.
module tb_buf_addr_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_pkt_req = 1'b0;
  logic        out_pkt_ack;
  logic        in_pkt_eop = 1'b0;
  logic [10:0] addr2data_waddr;
  logic        addr2data_waddr_wr;
  logic        in_ebm_ready = 1'b0;
  logic [10:0] addr2data_raddr;
  logic        addr2data_raddr_wr;
  logic        in_rd_done = 1'b0;
  logic [4:0]  out_free_cnt;
  logic [4:0]  out_pkt_cnt;
  logic        out_init_done;

  int n_chk = 0;
  int n_bad = 0;

  logic [3:0]  model_free[$];
  logic [3:0]  model_desc[$];
  logic [10:0] exp_wq[$];
  logic [10:0] exp_rq[$];
  bit          w_fl = 1'b0;
  bit          r_fl = 1'b0;

  buf_addr_sched dut (
    .clk                (clk),
    .rst                (rst),
    .in_pkt_req         (in_pkt_req),
    .out_pkt_ack        (out_pkt_ack),
    .in_pkt_eop         (in_pkt_eop),
    .addr2data_waddr    (addr2data_waddr),
    .addr2data_waddr_wr (addr2data_waddr_wr),
    .in_ebm_ready       (in_ebm_ready),
    .addr2data_raddr    (addr2data_raddr),
    .addr2data_raddr_wr (addr2data_raddr_wr),
    .in_rd_done         (in_rd_done),
    .out_free_cnt       (out_free_cnt),
    .out_pkt_cnt        (out_pkt_cnt),
    .out_init_done      (out_init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] a_of(input logic [3:0] s);
    return {s, 7'b0};
  endfunction

  // Output monitor: pops expected addresses on strobes and tracks in-flight slots for the invariant.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_pkt_ack || addr2data_waddr_wr)
          check("ack_eq_wr", 32'(out_pkt_ack), 32'(addr2data_waddr_wr));
        if (addr2data_waddr_wr) begin
          w_fl = 1'b1;
          if (exp_wq.size() == 0) check("waddr_spurious", 32'(addr2data_waddr_wr), 0);
          else check("waddr", 32'(addr2data_waddr), 32'(exp_wq.pop_front()));
        end
        if (addr2data_raddr_wr) begin
          r_fl = 1'b1;
          if (exp_rq.size() == 0) check("raddr_spurious", 32'(addr2data_raddr_wr), 0);
          else check("raddr", 32'(addr2data_raddr), 32'(exp_rq.pop_front()));
        end
        if (out_init_done)
          check("invariant", 32'(out_free_cnt) + 32'(out_pkt_cnt) + 32'(w_fl) + 32'(r_fl), 16);
      end
      @(posedge clk);
      if (rst) begin
        w_fl = 1'b0;
        r_fl = 1'b0;
      end else begin
        if (in_pkt_eop) w_fl = 1'b0;
        if (in_rd_done) r_fl = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_pkt_req = 1'b0;
    in_pkt_eop = 1'b0;
    in_ebm_ready = 1'b0;
    in_rd_done = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'({addr2data_waddr, addr2data_raddr}), 0);
    check("rst_ctl", 32'({out_pkt_ack, addr2data_waddr_wr, addr2data_raddr_wr,
                          out_free_cnt, out_pkt_cnt, out_init_done}), 0);
    model_free.delete();
    model_desc.delete();
    exp_wq.delete();
    exp_rq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("init_free", 32'(out_free_cnt), 32'(k));
      check("init_not_done", 32'(out_init_done), 0);
    end
    @(negedge clk);
    check("init_done", 32'(out_init_done), 1);
    check("init_free16", 32'(out_free_cnt), 16);
    check("init_pkt0", 32'(out_pkt_cnt), 0);
    for (int i = 0; i < 16; i++) model_free.push_back(4'(i));
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_pkt_ack) break;
    end
  endtask

  task automatic wr_pkt();
    logic [3:0] s;
    int n;
    s = model_free.pop_front();
    exp_wq.push_back(a_of(s));
    in_pkt_req = 1'b1;
    wait_ack(n);
    in_pkt_req = 1'b0;
    check("wr_ack_lat", 32'(n), 1);
    in_pkt_eop = 1'b1;
    @(negedge clk);
    in_pkt_eop = 1'b0;
    model_desc.push_back(s);
    check("wr_pkt_cnt", 32'(out_pkt_cnt), 32'(model_desc.size()));
    check("wr_free_cnt", 32'(out_free_cnt), 32'(model_free.size()));
  endtask

  task automatic rd_issue(output logic [3:0] s);
    int n;
    s = model_desc.pop_front();
    exp_rq.push_back(a_of(s));
    in_ebm_ready = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (addr2data_raddr_wr) break;
    end
    in_ebm_ready = 1'b0;
    check("rd_lat", 32'(n), 1);
  endtask

  task automatic rd_pkt();
    logic [3:0] s;
    rd_issue(s);
    in_rd_done = 1'b1;
    @(negedge clk);
    in_rd_done = 1'b0;
    model_free.push_back(s);
    check("rd_free_cnt", 32'(out_free_cnt), 32'(model_free.size()));
    check("rd_pkt_cnt", 32'(out_pkt_cnt), 32'(model_desc.size()));
  endtask

  initial begin
    logic [3:0] s;
    logic [3:0] w;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    do_reset();

    // Single packet through write and read.
    wr_pkt();
    rd_pkt();
    check("single_free", 32'(out_free_cnt), 16);

    // Fill all slots from a fresh free list, then a 17th request must stall.
    do_reset();
    for (int i = 0; i < 16; i++) wr_pkt();
    check("full_free0", 32'(out_free_cnt), 0);
    in_pkt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_no_ack", 32'(out_pkt_ack), 0);
    end
    rd_issue(s);
    in_rd_done = 1'b1;
    model_free.push_back(s);
    w = model_free.pop_front();
    exp_wq.push_back(a_of(w));
    @(negedge clk);
    in_rd_done = 1'b0;
    check("release_no_ack_yet", 32'(out_pkt_ack), 0);
    @(negedge clk);
    check("release_ack", 32'(out_pkt_ack), 1);
    in_pkt_req = 1'b0;

    // eop and read pop in the same cycle.
    s = model_desc.pop_front();
    exp_rq.push_back(a_of(s));
    model_desc.push_back(w);
    in_pkt_eop = 1'b1;
    in_ebm_ready = 1'b1;
    @(negedge clk);
    in_pkt_eop = 1'b0;
    in_ebm_ready = 1'b0;
    check("concur_rd_strobe", 32'(addr2data_raddr_wr), 1);
    check("concur_pkt_cnt", 32'(out_pkt_cnt), 32'(model_desc.size()));
    in_rd_done = 1'b1;
    @(negedge clk);
    in_rd_done = 1'b0;
    model_free.push_back(s);

    // rd_done release and write alloc in the same cycle.
    rd_issue(s);
    w = model_free.pop_front();
    exp_wq.push_back(a_of(w));
    model_free.push_back(s);
    in_pkt_req = 1'b1;
    in_rd_done = 1'b1;
    @(negedge clk);
    in_pkt_req = 1'b0;
    in_rd_done = 1'b0;
    check("concur_ack", 32'(out_pkt_ack), 1);
    check("concur_free_cnt", 32'(out_free_cnt), 32'(model_free.size()));
    in_pkt_eop = 1'b1;
    @(negedge clk);
    in_pkt_eop = 1'b0;
    model_desc.push_back(w);
    while (model_desc.size() != 0) rd_pkt();
    check("drain_free", 32'(out_free_cnt), 16);
    check("drain_pkt", 32'(out_pkt_cnt), 0);

    // FIFO order and pointer wrap across two full rounds.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) wr_pkt();
      for (int i = 0; i < 16; i++) rd_pkt();
    end
    check("wrap_free", 32'(out_free_cnt), 16);

    // Reset while a packet is being written with three stored.
    for (int i = 0; i < 3; i++) wr_pkt();
    s = model_free.pop_front();
    exp_wq.push_back(a_of(s));
    in_pkt_req = 1'b1;
    begin
      int n;
      wait_ack(n);
      check("busy_ack_lat", 32'(n), 1);
    end
    in_pkt_req = 1'b0;
    check("pre_rst_pkt", 32'(out_pkt_cnt), 3);
    do_reset();
    wr_pkt();
    rd_pkt();
    check("post_rst_free", 32'(out_free_cnt), 16);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/buf_addr_sched.md
Name: buf_addr_sched

Overview:
- Buffer-slot allocator and read scheduler for the 2048x134 packet cache RAM.
- Splits the RAM into 16 fixed slots of 128 words each.
- Write side: hands a free slot base address to the cache write port when the ingress side requests to store a packet.
- Read side: queues stored packets in FIFO order, issues read base addresses when egress is ready, and returns each slot to the free list once its read completes.

Parameters:
- SLOT_NUM, 16, number of buffer slots (power of two).
- SLOT_W, 4, slot index width (log2 SLOT_NUM).
- SLOT_SHIFT, 7, log2 of words per slot (128).
- ADDR_W, 11, cache RAM address width (SLOT_W + SLOT_SHIFT).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- in_pkt_req  input  1  ingress has a packet pending; level, held until acked.
- out_pkt_ack  output  1  one-cycle grant; ingress starts sending data to cache.
- in_pkt_eop  input  1  one-cycle pulse; last word of granted packet accepted by cache.
- addr2data_waddr  output  11  write base address (slot<<SLOT_SHIFT).
- addr2data_waddr_wr  output  1  one-cycle strobe for addr2data_waddr.
- in_ebm_ready  input  1  egress can accept a whole packet.
- addr2data_raddr  output  11  read base address.
- addr2data_raddr_wr  output  1  one-cycle strobe for addr2data_raddr.
- in_rd_done  input  1  one-cycle pulse; cache finished outputting packet (its valid_wr strobe).
- out_free_cnt  output  5  free slots, 0..16.
- out_pkt_cnt  output  5  stored packets awaiting read, 0..16.
- out_init_done  output  1  free list initialised.

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, both FSMs to initial state, both FIFOs empty, all counters 0.
- Internal storage:
  - free FIFO: 16x4, circular pointers, wraps 15->0.
  - desc FIFO: 16x4, same structure.
  - Counts are 5-bit. Neither FIFO can overflow because total slots = 16; an overflow push is an assertion error.
- Write FSM, W_INIT:
  - Cycle k after reset release (k=0..15): push slot k to the free FIFO; out_free_cnt increments.
  - After slot 15 is pushed: out_init_done=1 from the next cycle, go to W_IDLE.
- Write FSM, W_IDLE:
  - If in_pkt_req=1 and free_cnt>0: pop the free FIFO head into cur_wslot.
  - Next cycle: addr2data_waddr={cur_wslot,7'b0}, addr2data_waddr_wr=1, out_pkt_ack=1 (both single-cycle, same cycle). Go to W_BUSY.
  - If free_cnt=0: stay in W_IDLE, no ack; ingress back-pressured.
- Write FSM, W_BUSY:
  - Wait for in_pkt_eop. On eop, push cur_wslot to the desc FIFO and go to W_IDLE.
  - in_pkt_req is ignored while in W_BUSY.
- Write latency: in_pkt_req sampled to ack/waddr_wr is 1 cycle.
- addr2data_waddr holds its last value between strobes.
- Read FSM, R_IDLE:
  - If out_init_done=1, pkt_cnt>0 and in_ebm_ready=1: pop the desc head into cur_rslot.
  - Next cycle: addr2data_raddr={cur_rslot,7'b0}, addr2data_raddr_wr=1 for one cycle. Go to R_WAIT.
- Read FSM, R_WAIT:
  - Wait for in_rd_done. On it, push cur_rslot to the free FIFO and go to R_IDLE.
  - in_rd_done is ignored outside R_WAIT.
- Only one read is outstanding at a time. The next read strobe comes at least 2 cycles after in_rd_done.
- Simultaneous events:
  - Free FIFO push (read release) and pop (write alloc) in the same cycle: both happen, free_cnt unchanged. This is legal with free_cnt=0 only if the popped entry is the one pushed earlier, so a pop requires free_cnt>0 registered before the edge; no same-cycle bypass.
  - desc FIFO push (eop) and pop (read issue) in the same cycle: both happen, pkt_cnt unchanged. A pop requires registered pkt_cnt>0.
  - in_pkt_eop in the same cycle as entering W_BUSY is not possible (ack precedes data).
- Counters: out_free_cnt and out_pkt_cnt are registered. They update 1 cycle after the push/pop edge and equal the FIFO occupancy. Invariant when both FSMs are idle: free_cnt + pkt_cnt = 16.
- Reset mid-operation: any state, both FIFOs flushed, returns to W_INIT/R_IDLE. The in-flight packet is discarded and the full 16-cycle init is re-executed.

Test Plan:
- Init: release rst, hold requests low -> out_free_cnt counts 1..16 over 16 cycles; out_init_done=1 on cycle 17; no strobes.
- Single packet: in_pkt_req=1 at cycle T -> ack+waddr_wr at T+1 with waddr=0x000. Then eop -> pkt_cnt=1. in_ebm_ready=1 -> raddr_wr with raddr=0x000. Then rd_done -> free_cnt=16, pkt_cnt=0.
- Fill: 16 back-to-back packets, ebm_ready=0 -> waddr 0x000,0x080,...,0x780. 17th request gets no ack while free_cnt=0. Ack comes 1 cycle after the first rd_done releases slot 0, with waddr=0x000.
- FIFO order / wrap: write slots 0..15, read all, write 16 more -> read addresses follow write order; pointers wrap, no loss or duplication.
- Concurrency: eop and read-pop in the same cycle, and rd_done and alloc-pop in the same cycle -> counts unchanged, invariant free+pkt(+in-flight)=16 holds every cycle.
- Reset mid-packet: assert rst during W_BUSY with pkt_cnt=3 -> all outputs 0 next cycle, re-init completes in 16 cycles, free_cnt=16.
